task_mem_streamer: RTL

TASK_MEM_STREAMER -- requirements
Module: task_mem_streamer

---
 rtl/task_mem_pkg.sv | 13 +
 rtl/task_mem_array.sv | 37 +++
 rtl/task_mem_streamer.sv | 117 +++++++++++
 3 files changed

// File: rtl/task_mem_pkg.sv
// Shared defaults, STOP opcode value and FSM state encoding for the task memory streamer.
package task_mem_pkg;
   localparam int DEF_INSN_SIZE      = 16;
   localparam int DEF_INSN_COUNT     = 16;
   localparam int DEF_TASK_MEM_DEPTH = 8;

   localparam logic [3:0] STOP_OP = 4'hF;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;
endpackage

// File: rtl/task_mem_array.sv
// Register-based task storage: TASK_MEM_DEPTH tasks x INSN_COUNT words, one write port, one
// combinational read port. Every word clears on reset.
module task_mem_array
   import task_mem_pkg::*;
#(
   parameter int INSN_SIZE      = DEF_INSN_SIZE,
   parameter int INSN_COUNT     = DEF_INSN_COUNT,
   parameter int TASK_MEM_DEPTH = DEF_TASK_MEM_DEPTH
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          wr_en,
   input  logic [$clog2(TASK_MEM_DEPTH)-1:0] wr_task,
   input  logic [$clog2(INSN_COUNT)-1:0] wr_idx,
   input  logic [INSN_SIZE-1:0]          wr_data,
   input  logic [$clog2(TASK_MEM_DEPTH)-1:0] rd_task,
   input  logic [$clog2(INSN_COUNT)-1:0] rd_idx,
   output logic [INSN_SIZE-1:0]          rd_data
);

   logic [INSN_SIZE-1:0] mem [TASK_MEM_DEPTH][INSN_COUNT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int t = 0; t < TASK_MEM_DEPTH; t++) begin
            for (int i = 0; i < INSN_COUNT; i++) begin
               mem[t][i] <= '0;
            end
         end
      end else if (wr_en) begin
         mem[wr_task][wr_idx] <= wr_data;
      end
   end

   assign rd_data = mem[rd_task][rd_idx];

endmodule

// File: rtl/task_mem_streamer.sv
// Task fetch FSM: accepts a task id, then streams that task's instructions one beat per cycle.
// Optional macro TASK_MEM_STOP_EN ends a task early on a word whose top nibble is the STOP opcode.
module task_mem_streamer
   import task_mem_pkg::*;
#(
   parameter int INSN_SIZE      = DEF_INSN_SIZE,
   parameter int INSN_COUNT     = DEF_INSN_COUNT,
   parameter int TASK_MEM_DEPTH = DEF_TASK_MEM_DEPTH
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              wr_en,
   input  logic [$clog2(TASK_MEM_DEPTH)-1:0] wr_task,
   input  logic [$clog2(INSN_COUNT)-1:0]     wr_idx,
   input  logic [INSN_SIZE-1:0]              wr_data,
   output logic                              wr_err,
   input  logic                              req_valid,
   // One extra bit so that out-of-range task ids (>= TASK_MEM_DEPTH) can be requested.
   input  logic [$clog2(TASK_MEM_DEPTH):0]   req_task,
   output logic                              req_ready,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [INSN_SIZE-1:0]              out_data,
   output logic [$clog2(INSN_COUNT)-1:0]     out_idx,
   output logic                              out_last,
   output logic                              out_err
);

   localparam int TW = $clog2(TASK_MEM_DEPTH);
   localparam int IW = $clog2(INSN_COUNT);
   localparam int RW = TW + 1;

   state_t               state;
   logic [RW-1:0]        cur_task;
   logic [IW-1:0]        idx;
   logic                 err_beat;
   logic [INSN_SIZE-1:0] rd_data;
   logic                 stop_hit;
   logic                 fire;
   logic                 wr_block;
   logic                 wr_ok;

   // Writes into the task being streamed are refused so the stream content stays coherent.
   assign wr_block = wr_en && (state == STREAM) && ({1'b0, wr_task} == cur_task);
   assign wr_ok    = wr_en && !wr_block && ({1'b0, wr_task} < RW'(TASK_MEM_DEPTH));

   task_mem_array #(
      .INSN_SIZE      (INSN_SIZE),
      .INSN_COUNT     (INSN_COUNT),
      .TASK_MEM_DEPTH (TASK_MEM_DEPTH)
   ) u_array (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_ok),
      .wr_task (wr_task),
      .wr_idx  (wr_idx),
      .wr_data (wr_data),
      .rd_task (cur_task[TW-1:0]),
      .rd_idx  (idx),
      .rd_data (rd_data)
   );

`ifdef TASK_MEM_STOP_EN
   assign stop_hit = (rd_data[INSN_SIZE-1 -: 4] == STOP_OP);
`else
   assign stop_hit = 1'b0;
`endif

   assign out_data = (out_valid && !err_beat) ? rd_data : '0;
   assign out_idx  = idx;
   assign out_err  = out_valid && err_beat;
   assign out_last = out_valid && (err_beat || (idx == IW'(INSN_COUNT - 1)) || stop_hit);
   assign fire     = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cur_task  <= '0;
         idx       <= '0;
         err_beat  <= 1'b0;
         req_ready <= 1'b0;
         out_valid <= 1'b0;
         wr_err    <= 1'b0;
      end else begin
         wr_err <= wr_block;
         case (state)
            IDLE: begin
               if (req_ready && req_valid) begin
                  state     <= STREAM;
                  cur_task  <= req_task;
                  idx       <= '0;
                  err_beat  <= (req_task >= RW'(TASK_MEM_DEPTH));
                  req_ready <= 1'b0;
                  out_valid <= 1'b1;
               end else begin
                  req_ready <= 1'b1;
               end
            end
            STREAM: begin
               if (fire) begin
                  if (out_last) begin
                     state     <= IDLE;
                     idx       <= '0;
                     err_beat  <= 1'b0;
                     req_ready <= 1'b1;
                     out_valid <= 1'b0;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
